reg_file_2r1w: RTL

//  32x32 general-purpose register file: two registered read ports, one write port.

---
 rtl/reg_file_2r1w_pkg.sv | 17 +
 rtl/reg_file_2r1w_if.sv | 31 +++
 rtl/reg_file_2r1w_clear_seq.sv | 55 +++++
 rtl/reg_file_2r1w.sv | 92 +++++++++
 4 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file.
//   rf_state_e     : clear-sequencer states (RF_CLEAR while zeroing storage, RF_READY after)
//   RF_ZERO_IDX    : index of the hardwired-zero entry
//   RF_DATA_WIDTH  : default register width
//   RF_ADDR_WIDTH  : default register index width
package rf_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

  localparam int RF_ZERO_IDX   = 0;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus interface for reg_file_2r1w.
//   ReadAddrA/B : read port indices (master -> slave)
//   ReadDataA/B : registered read data, 1-cycle latency (slave -> master)
//   WriteEn/WriteAddr/WriteData : write request (master -> slave)
//   Busy        : clear sequence in progress (slave -> master)
// Modports: master (execute-path side / testbench), slave (register file).
interface reg_file_2r1w_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] ReadAddrA;
  logic [ADDR_WIDTH-1:0] ReadAddrB;
  logic [DATA_WIDTH-1:0] ReadDataA;
  logic [DATA_WIDTH-1:0] ReadDataB;
  logic                  WriteEn;
  logic [ADDR_WIDTH-1:0] WriteAddr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  Busy;

  modport master (
    output ReadAddrA, ReadAddrB, WriteEn, WriteAddr, WriteData,
    input  ReadDataA, ReadDataB, Busy
  );

  modport slave (
    input  ReadAddrA, ReadAddrB, WriteEn, WriteAddr, WriteData,
    output ReadDataA, ReadDataB, Busy
  );

endinterface

// File: rtl/reg_file_2r1w_clear_seq.sv
// rf_clear_seq: post-reset clear sequencer for reg_file_2r1w.
// After reset it walks ClearIdx from 0 to DEPTH-1, one entry per cycle,
// asserting ClearWe; the edge that covers entry DEPTH-1 moves to RF_READY.
//   Clk      : clock, rising edge
//   Reset    : synchronous, active-high; restarts the sequence at entry 0
//   Busy     : registered, high while in RF_CLEAR
//   ClearWe  : write-enable for the zeroing write of entry ClearIdx
//   ClearIdx : entry currently being zeroed
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic                  Busy,
  output logic                  ClearWe,
  output logic [ADDR_WIDTH-1:0] ClearIdx
);

  rf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  busy_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == '1) begin
            state_q <= RF_READY;
            busy_q  <= 1'b0;
          end
        end
        RF_READY: begin
          state_q <= RF_READY;
        end
        default: begin
          state_q <= RF_CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign ClearWe  = busy_q;
  assign ClearIdx = idx_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: 32x32 register file, two registered read ports, one write port.
// Entry 0 reads as zero and ignores writes. After reset the rf_clear_seq
// sub-module zeroes the storage one entry per cycle (so the array itself
// has no reset); during that time writes are ignored and reads return 0.
//   Clk   : clock, rising edge
//   Reset : synchronous, active-high
//   bus   : reg_file_2r1w_if.slave (read ports A/B, write port, Busy)
// Build option: define REGFILE_BYPASS_EN for write-first same-cycle
// read/write of a nonzero address; otherwise reads are read-first.
module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  reg_file_2r1w_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  busy;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_idx;

  logic                  ext_we;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  logic [DATA_WIDTH-1:0] rdata_a_d, rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_d, rdata_b_q;

  rf_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .Clk      (Clk),
    .Reset    (Reset),
    .Busy     (busy),
    .ClearWe  (clear_we),
    .ClearIdx (clear_idx)
  );

  // Single write port shared by the clear sequencer and the external bus;
  // clear_we and ext_we are mutually exclusive since ext_we requires !busy.
  always_comb begin
    ext_we = !busy && bus.WriteEn && (bus.WriteAddr != ZERO_IDX);
    we     = !Reset && (clear_we || ext_we);
    waddr  = clear_we ? clear_idx : bus.WriteAddr;
    wdata  = clear_we ? '0 : bus.WriteData;
  end

  always_ff @(posedge Clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a_d = '0;
    rdata_b_d = '0;
    if (!busy) begin
      if (bus.ReadAddrA != ZERO_IDX) rdata_a_d = mem_q[bus.ReadAddrA];
      if (bus.ReadAddrB != ZERO_IDX) rdata_b_d = mem_q[bus.ReadAddrB];
`ifdef REGFILE_BYPASS_EN
      // ext_we already excludes entry 0 and Busy, so a match implies both.
      if (ext_we && (bus.WriteAddr == bus.ReadAddrA)) rdata_a_d = bus.WriteData;
      if (ext_we && (bus.WriteAddr == bus.ReadAddrB)) rdata_b_d = bus.WriteData;
`else
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign bus.ReadDataA = rdata_a_q;
  assign bus.ReadDataB = rdata_b_q;
  assign bus.Busy      = busy;

endmodule
